// File: rtl/fmac_issue_ctrl_if.sv
// Request, MAC datapath, result and CSR signals of the FMA issue controller.
// slave = controller side, master = requester/datapath/consumer side.
interface fmac_issue_ctrl_if #(
    parameter int PARM_TAG   = 4,
    parameter int PARM_RM    = 3,
    parameter int PARM_WIDTH = 32
);
    logic                  Req_valid_i;
    logic                  Req_ready_o;
    logic [PARM_RM-1:0]    Req_rm_i;
    logic [PARM_TAG-1:0]   Req_tag_i;
    logic                  Mac_issue_o;
    logic [PARM_RM-1:0]    Mac_rm_o;
    logic [PARM_WIDTH-1:0] Mac_result_i;
    logic [3:0]            Mac_flags_i;
    logic                  Out_valid_o;
    logic                  Out_ready_i;
    logic [PARM_TAG-1:0]   Out_tag_o;
    logic [PARM_WIDTH-1:0] Out_result_o;
    logic                  Out_illegal_o;
    logic                  Csr_we_i;
    logic                  Csr_sel_i;
    logic [4:0]            Csr_wdata_i;
    logic [2:0]            Frm_o;
    logic [4:0]            Fflags_o;

    modport slave (
        input  Req_valid_i, Req_rm_i, Req_tag_i,
        input  Mac_result_i, Mac_flags_i,
        input  Out_ready_i,
        input  Csr_we_i, Csr_sel_i, Csr_wdata_i,
        output Req_ready_o, Mac_issue_o, Mac_rm_o,
        output Out_valid_o, Out_tag_o, Out_result_o, Out_illegal_o,
        output Frm_o, Fflags_o
    );

    modport master (
        output Req_valid_i, Req_rm_i, Req_tag_i,
        output Mac_result_i, Mac_flags_i,
        output Out_ready_i,
        output Csr_we_i, Csr_sel_i, Csr_wdata_i,
        input  Req_ready_o, Mac_issue_o, Mac_rm_o,
        input  Out_valid_o, Out_tag_o, Out_result_o, Out_illegal_o,
        input  Frm_o, Fflags_o
    );
endinterface

// File: rtl/fmac_issue_ctrl.sv
// Issue/retire controller for the fixed-latency FMA pipeline, owning FRM/FFLAGS.
// Define FMAC_FLUSH_EN to add Flush_i, which discards in-flight ops and queued results.
module fmac_issue_ctrl #(
    parameter int PARM_LATENCY   = 4,
    parameter int PARM_TAG       = 4,
    parameter int PARM_BUF_DEPTH = 4,
    parameter int PARM_RM        = 3,
    parameter int PARM_WIDTH     = 32
) (
    input  logic Clk_i,
    input  logic Rst_n_i,
`ifdef FMAC_FLUSH_EN
    input  logic Flush_i,
`endif
    fmac_issue_ctrl_if.slave bus
);

    localparam int PW = $clog2(PARM_BUF_DEPTH);
    localparam int CW = $clog2(PARM_BUF_DEPTH + 1);

    typedef struct packed {
        logic                v;
        logic                ill;
        logic [PARM_TAG-1:0] tag;
    } slot_t;

    typedef struct packed {
        logic [PARM_TAG-1:0]   tag;
        logic                  ill;
        logic [PARM_WIDTH-1:0] res;
    } entry_t;

    slot_t  [PARM_LATENCY-1:0]   slot_q, slot_d;
    entry_t [PARM_BUF_DEPTH-1:0] mem_q, mem_d;
    logic   [PW-1:0]             wr_q, wr_d;
    logic   [PW-1:0]             rd_q, rd_d;
    logic   [CW-1:0]             cnt_q, cnt_d;
    logic   [2:0]                frm_q, frm_d;
    logic   [4:0]                fflags_q, fflags_d;
    logic   [PARM_RM-1:0]        mac_rm_q, mac_rm_d;
    logic                        run_q, run_d;

    logic               flush;
    logic [PARM_RM-1:0] rm_eff;
    logic               rm_ill;
    logic [31:0]        inflight;
    logic               ready;
    logic               accept;
    logic               issue;
    slot_t              last;
    logic               push;
    logic               pop;
    logic               out_valid;
    entry_t             head;
    logic [4:0]         ret_flags;

`ifdef FMAC_FLUSH_EN
    assign flush = Flush_i;
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        rm_eff = bus.Req_rm_i;
        if (bus.Req_rm_i == {PARM_RM{1'b1}}) begin
            rm_eff = PARM_RM'(frm_q);
        end
        rm_ill = rm_eff > PARM_RM'(4);

        inflight = '0;
        for (int i = 0; i < PARM_LATENCY; i++) begin
            inflight = inflight + 32'(slot_q[i].v);
        end

        // Every tracked op owns a FIFO slot in advance, so retire never overflows.
        ready  = run_q & ~flush &
                 ((inflight + 32'(cnt_q)) < 32'(PARM_BUF_DEPTH));
        accept = bus.Req_valid_i & ready;
        issue  = accept & ~rm_ill;

        last      = slot_q[PARM_LATENCY-1];
        push      = last.v & ~flush;
        out_valid = cnt_q != '0;
        pop       = out_valid & bus.Out_ready_i;
        head      = mem_q[rd_q];

        ret_flags = '0;
        if (push && !last.ill) begin
            ret_flags = {bus.Mac_flags_i[3], 1'b0, bus.Mac_flags_i[2:0]};
        end
    end

    always_comb begin
        slot_d = '0;
        if (accept) begin
            slot_d[0] = '{v: 1'b1, ill: rm_ill, tag: bus.Req_tag_i};
        end
        for (int i = 1; i < PARM_LATENCY; i++) begin
            slot_d[i] = slot_q[i-1];
        end
        if (flush) begin
            slot_d = '0;
        end
    end

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = '{
                tag: last.tag,
                ill: last.ill,
                res: last.ill ? '0 : bus.Mac_result_i
            };
            wr_d = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_comb begin
        run_d    = 1'b1;
        mac_rm_d = issue ? rm_eff : mac_rm_q;
        frm_d    = frm_q;
        fflags_d = fflags_q | ret_flags;
        // A software write overrides history but still keeps this cycle's retire.
        if (bus.Csr_we_i) begin
            if (bus.Csr_sel_i) begin
                fflags_d = bus.Csr_wdata_i | ret_flags;
            end else begin
                frm_d = bus.Csr_wdata_i[2:0];
            end
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            slot_q   <= '0;
            mem_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            frm_q    <= '0;
            fflags_q <= '0;
            mac_rm_q <= '0;
            run_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            frm_q    <= frm_d;
            fflags_q <= fflags_d;
            mac_rm_q <= mac_rm_d;
            run_q    <= run_d;
        end
    end

    assign bus.Req_ready_o   = ready;
    assign bus.Mac_issue_o   = issue;
    assign bus.Mac_rm_o      = issue ? rm_eff : mac_rm_q;
    assign bus.Out_valid_o   = out_valid;
    assign bus.Out_tag_o     = out_valid ? head.tag : '0;
    assign bus.Out_result_o  = out_valid ? head.res : '0;
    assign bus.Out_illegal_o = out_valid & head.ill;
    assign bus.Frm_o         = frm_q;
    assign bus.Fflags_o      = fflags_q;

endmodule

// File: tb/tb_fmac_issue_ctrl.sv
// Directed bench for fmac_issue_ctrl with a MAC delay-line model and result scoreboard.
// Build with FMAC_FLUSH_EN to also exercise the flush path.
module tb_fmac_issue_ctrl;

    localparam int L = 4;
    localparam int D = 4;

    logic Clk_i   = 1'b0;
    logic Rst_n_i = 1'b1;
`ifdef FMAC_FLUSH_EN
    logic Flush_i = 1'b0;
`endif

    fmac_issue_ctrl_if bus ();

    fmac_issue_ctrl #(
        .PARM_LATENCY  (L),
        .PARM_TAG      (4),
        .PARM_BUF_DEPTH(D),
        .PARM_RM       (3),
        .PARM_WIDTH    (32)
    ) dut (
        .Clk_i  (Clk_i),
        .Rst_n_i(Rst_n_i),
`ifdef FMAC_FLUSH_EN
        .Flush_i(Flush_i),
`endif
        .bus    (bus)
    );

    always #5 Clk_i = ~Clk_i;

    typedef struct packed {
        logic [3:0]  tag;
        logic        ill;
        logic [31:0] res;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          pops   = 0;
    bit          last_acc;
    logic [2:0]  model_frm  = '0;
    logic [31:0] mac_res_nx = '0;
    logic [3:0]  mac_flg_nx = '0;

    // MAC datapath model: unused stages carry garbage the controller must ignore.
    logic [31:0] mp_res [L];
    logic [3:0]  mp_flg [L];

    always @(posedge Clk_i) begin
        for (int i = L - 1; i > 0; i--) begin
            mp_res[i] <= mp_res[i-1];
            mp_flg[i] <= mp_flg[i-1];
        end
        mp_res[0] <= bus.Mac_issue_o ? mac_res_nx : 32'hDEAD_BEEF;
        mp_flg[0] <= bus.Mac_issue_o ? mac_flg_nx : 4'hF;
    end

    assign bus.Mac_result_i = mp_res[L-1];
    assign bus.Mac_flags_i  = mp_flg[L-1];

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        logic [2:0] rm_eff;
        exp_t       e;
        #1;
        last_acc = bus.Req_valid_i && bus.Req_ready_o;
        if (last_acc) begin
            rm_eff = (bus.Req_rm_i == 3'b111) ? model_frm : bus.Req_rm_i;
            e.tag  = bus.Req_tag_i;
            e.ill  = rm_eff > 3'd4;
            e.res  = e.ill ? 32'd0 : mac_res_nx;
            exp_q.push_back(e);
        end
        if (bus.Csr_we_i && !bus.Csr_sel_i) begin
            model_frm = bus.Csr_wdata_i[2:0];
        end
        if (bus.Out_valid_o && bus.Out_ready_i) begin
            pops++;
            chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_tag", 32'(bus.Out_tag_o), 32'(e.tag));
                chk("out_illegal", 32'(bus.Out_illegal_o), 32'(e.ill));
                chk("out_result", bus.Out_result_o, e.res);
            end
        end
        @(negedge Clk_i);
    endtask

    task automatic req(input logic [2:0] rm, input logic [3:0] tag,
                       input logic [31:0] res, input logic [3:0] flg);
        bus.Req_valid_i = 1'b1;
        bus.Req_rm_i    = rm;
        bus.Req_tag_i   = tag;
        mac_res_nx      = res;
        mac_flg_nx      = flg;
    endtask

    task automatic idle();
        bus.Req_valid_i = 1'b0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        idle();
        bus.Out_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_out(output int n);
        n = 1;
        #1;
        while (!bus.Out_valid_o && n < 20) begin
            @(negedge Clk_i);
            #1;
            n++;
        end
    endtask

    initial begin
        int lat;
        int acc;
        int p0;

        bus.Req_valid_i = 1'b0;
        bus.Req_rm_i    = '0;
        bus.Req_tag_i   = '0;
        bus.Out_ready_i = 1'b1;
        bus.Csr_we_i    = 1'b0;
        bus.Csr_sel_i   = 1'b0;
        bus.Csr_wdata_i = '0;

        #1 Rst_n_i = 1'b0;
        #2;
        chk("rst_ready", 32'(bus.Req_ready_o), 32'd0);
        chk("rst_issue", 32'(bus.Mac_issue_o), 32'd0);
        chk("rst_mac_rm", 32'(bus.Mac_rm_o), 32'd0);
        chk("rst_out_valid", 32'(bus.Out_valid_o), 32'd0);
        chk("rst_out_tag", 32'(bus.Out_tag_o), 32'd0);
        chk("rst_out_result", bus.Out_result_o, 32'd0);
        chk("rst_out_illegal", 32'(bus.Out_illegal_o), 32'd0);
        chk("rst_frm", 32'(bus.Frm_o), 32'd0);
        chk("rst_fflags", 32'(bus.Fflags_o), 32'd0);
        repeat (2) @(negedge Clk_i);
        Rst_n_i = 1'b1;
        @(negedge Clk_i);
        chk("ready_after_rst", 32'(bus.Req_ready_o), 32'd1);

        // Dynamic rm resolved from FRM, then end-to-end latency
        bus.Csr_we_i    = 1'b1;
        bus.Csr_sel_i   = 1'b0;
        bus.Csr_wdata_i = 5'd3;
        tick();
        bus.Csr_we_i = 1'b0;
        chk("frm_write", 32'(bus.Frm_o), 32'd3);
        req(3'b111, 4'd5, 32'h3F80_0001, 4'b0001);
        #1;
        chk("dyn_issue", 32'(bus.Mac_issue_o), 32'd1);
        chk("dyn_rm", 32'(bus.Mac_rm_o), 32'd3);
        tick();
        idle();
        wait_out(lat);
        chk("dyn_latency", 32'(lat), 32'(L + 1));
        drain(20);
        chk("fflags_nx", 32'(bus.Fflags_o), 32'b00001);

        req(3'b000, 4'd6, 32'h4000_0000, 4'b0100);
        tick();
        drain(20);
        chk("fflags_accum", 32'(bus.Fflags_o), 32'b00101);

        // FRM write and dynamic request in the same cycle use the old FRM
        req(3'b111, 4'd9, 32'h1234_5678, 4'b0000);
        bus.Csr_we_i    = 1'b1;
        bus.Csr_sel_i   = 1'b0;
        bus.Csr_wdata_i = 5'd6;
        #1;
        chk("frm_same_issue", 32'(bus.Mac_issue_o), 32'd1);
        chk("frm_same_rm", 32'(bus.Mac_rm_o), 32'd3);
        tick();
        bus.Csr_we_i = 1'b0;
        req(3'b111, 4'd10, 32'h5555_0000, 4'b0000);
        #1;
        chk("frm_ill_issue", 32'(bus.Mac_issue_o), 32'd0);
        chk("frm_ill_rm_hold", 32'(bus.Mac_rm_o), 32'd3);
        tick();
        drain(20);
        chk("fflags_frm_ill", 32'(bus.Fflags_o), 32'b00101);

        // Illegal static rm between two legal ops
        req(3'b000, 4'd1, 32'h1111_0001, 4'b0000);
        tick();
        req(3'b101, 4'd2, 32'h7777_7777, 4'b1111);
        #1;
        chk("ill_issue", 32'(bus.Mac_issue_o), 32'd0);
        chk("ill_rm_hold", 32'(bus.Mac_rm_o), 32'd0);
        tick();
        req(3'b001, 4'd3, 32'h3333_0003, 4'b0000);
        #1;
        chk("ill_next_rm", 32'(bus.Mac_rm_o), 32'd1);
        tick();
        drain(20);
        chk("fflags_ill", 32'(bus.Fflags_o), 32'b00101);

        // Backpressure: credits run out at the buffer depth
        bus.Out_ready_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            req(3'b000, 4'(k), 32'h100 + k, 4'b0000);
            tick();
            if (last_acc) acc++;
        end
        idle();
        chk("bp_accepts", 32'(acc), 32'(D));
        chk("bp_ready_low", 32'(bus.Req_ready_o), 32'd0);
        chk("bp_head_valid", 32'(bus.Out_valid_o), 32'd1);
        bus.Out_ready_i = 1'b1;
        tick();
        chk("bp_ready_back", 32'(bus.Req_ready_o), 32'd1);
        drain(20);

        // FFLAGS write coincident with a retire
        req(3'b000, 4'd7, 32'hABCD_0001, 4'b0001);
        tick();
        idle();
        repeat (3) tick();
        bus.Csr_we_i    = 1'b1;
        bus.Csr_sel_i   = 1'b1;
        bus.Csr_wdata_i = 5'b10000;
        tick();
        bus.Csr_we_i = 1'b0;
        chk("fflags_wr_retire", 32'(bus.Fflags_o), 32'b10001);
        drain(20);

        // Asynchronous reset with ops queued and in flight
        bus.Out_ready_i = 1'b0;
        req(3'b000, 4'd11, 32'h0B00_0000, 4'b1000);
        tick();
        req(3'b000, 4'd12, 32'h0C00_0000, 4'b1000);
        tick();
        req(3'b000, 4'd13, 32'h0D00_0000, 4'b1000);
        tick();
        idle();
        repeat (3) tick();
        chk("pre_rst_valid", 32'(bus.Out_valid_o), 32'd1);
        #2 Rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.Out_valid_o), 32'd0);
        chk("mid_rst_fflags", 32'(bus.Fflags_o), 32'd0);
        chk("mid_rst_frm", 32'(bus.Frm_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.Req_ready_o), 32'd0);
        exp_q.delete();
        model_frm = '0;
        @(negedge Clk_i);
        Rst_n_i = 1'b1;
        @(negedge Clk_i);
        p0 = pops;
        bus.Out_ready_i = 1'b1;
        repeat (10) tick();
        chk("rst_no_stale", 32'(pops - p0), 32'd0);
        chk("rst_fflags_clean", 32'(bus.Fflags_o), 32'd0);

`ifdef FMAC_FLUSH_EN
        // Flush with one result queued and two ops in flight
        bus.Out_ready_i = 1'b0;
        req(3'b000, 4'd1, 32'hF100_0000, 4'b0000);
        tick();
        idle();
        repeat (2) tick();
        req(3'b000, 4'd2, 32'hF200_0000, 4'b1000);
        tick();
        req(3'b000, 4'd3, 32'hF300_0000, 4'b1000);
        tick();
        chk("pre_flush_valid", 32'(bus.Out_valid_o), 32'd1);
        req(3'b000, 4'd4, 32'hF400_0000, 4'b1000);
        Flush_i = 1'b1;
        #1;
        chk("flush_ready", 32'(bus.Req_ready_o), 32'd0);
        tick();
        chk("flush_no_accept", 32'(last_acc), 32'd0);
        Flush_i = 1'b0;
        idle();
        chk("flush_valid", 32'(bus.Out_valid_o), 32'd0);
        exp_q.delete();
        p0 = pops;
        bus.Out_ready_i = 1'b1;
        repeat (8) tick();
        chk("flush_no_stale", 32'(pops - p0), 32'd0);
        chk("flush_fflags", 32'(bus.Fflags_o), 32'd0);
`endif

        // A fresh op after reset (and flush) goes through normally
        req(3'b100, 4'd8, 32'hC0DE_0008, 4'b0010);
        #1;
        chk("post_issue", 32'(bus.Mac_issue_o), 32'd1);
        chk("post_rm", 32'(bus.Mac_rm_o), 32'd4);
        tick();
        drain(20);
        chk("post_fflags", 32'(bus.Fflags_o), 32'b00010);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
